// File: rtl/sevenseg_display_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Provides the arbiter state enum and the display word/blank encodings.
package sevenseg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        OPEN
    } arb_state_t;

    localparam int          DIGITS     = 8;
    localparam int          NIB_W      = 4;
    localparam int          WORD_W     = DIGITS * NIB_W;
    localparam logic [3:0]  BLANK_NIB  = 4'hF;
    localparam logic [31:0] BLANK_WORD = {DIGITS{BLANK_NIB}};

endpackage

// File: rtl/sevenseg_display_arbiter_if.sv
// Requester <-> arbiter bundle: req/req_digits(/blink) in, gnt/owner_id/busy/
// switched/disp_digits out. blink exists only with SEVENSEG_ARB_BLINK_EN.
interface sevenseg_display_arbiter_if #(
    parameter int N_REQ = 4
);
    import sevenseg_pkg::*;

    logic [N_REQ-1:0]        req;
    logic [WORD_W*N_REQ-1:0] req_digits;
`ifdef SEVENSEG_ARB_BLINK_EN
    logic [N_REQ-1:0]        blink;
`endif
    logic [N_REQ-1:0]        gnt;
    logic [2:0]              owner_id;
    logic                    busy;
    logic                    switched;
    logic [WORD_W-1:0]       disp_digits;

`ifdef SEVENSEG_ARB_BLINK_EN
    modport master (
        output req, req_digits, blink,
        input  gnt, owner_id, busy, switched, disp_digits
    );
    modport slave (
        input  req, req_digits, blink,
        output gnt, owner_id, busy, switched, disp_digits
    );
`else
    modport master (
        output req, req_digits,
        input  gnt, owner_id, busy, switched, disp_digits
    );
    modport slave (
        input  req, req_digits,
        output gnt, owner_id, busy, switched, disp_digits
    );
`endif

endinterface

// File: rtl/sevenseg_display_arbiter_rr_pick.sv
// Combinational round-robin picker: first index >= rr_ptr (wrapping) whose
// req is set and not excluded. Ports: req, rr_ptr, excl in; found, idx out.
module sevenseg_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       rr_ptr,
    input  logic [N_REQ-1:0] excl,
    output logic             found,
    output logic [2:0]       idx
);

    logic [N_REQ-1:0] cand;

    always_comb begin
        cand  = req & ~excl;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < N_REQ; off++) begin
            if (!found && cand[(int'(rr_ptr) + off) % N_REQ]) begin
                found = 1'b1;
                idx   = 3'((int'(rr_ptr) + off) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/sevenseg_display_arbiter.sv
// Round-robin owner arbitration of one 8-digit display with minimum hold.
// Ports: clk, reset_n, bus (slave). Optional blink via SEVENSEG_ARB_BLINK_EN.
module sevenseg_display_arbiter
    import sevenseg_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 50_000
`ifdef SEVENSEG_ARB_BLINK_EN
    ,
    parameter int BLINK_LOG2  = 24
`endif
) (
    input  logic                        clk,
    input  logic                        reset_n,
    sevenseg_display_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [2:0]        owner_q, owner_d;
    logic              busy_q, busy_d;
    logic              switched_q, switched_d;
    logic [2:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [WORD_W-1:0] disp_q, disp_d;
`ifdef SEVENSEG_ARB_BLINK_EN
    logic [BLINK_LOG2:0] blink_cnt_q, blink_cnt_d;
`endif

    logic              pick_found;
    logic [2:0]        pick_idx;
    logic [N_REQ-1:0]  excl;
    logic              owner_req;
    logic              grant;
    logic [WORD_W-1:0] sel_word;
    logic              sel_blink;

    // Idle excludes nobody; otherwise the current owner is never re-picked.
    assign excl      = (state_q == IDLE) ? '0 : gnt_q;
    assign owner_req = |(bus.req & gnt_q);

    sevenseg_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr_q),
        .excl   (excl),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            busy_q      <= 1'b0;
            switched_q  <= 1'b0;
            rr_ptr_q    <= '0;
            hold_cnt_q  <= '0;
            disp_q      <= BLANK_WORD;
`ifdef SEVENSEG_ARB_BLINK_EN
            blink_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            switched_q  <= switched_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            disp_q      <= disp_d;
`ifdef SEVENSEG_ARB_BLINK_EN
            blink_cnt_q <= blink_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) grant = 1'b1;
            end
            HOLD: begin
                if (!owner_req) begin
                    if (pick_found) grant = 1'b1;
                    else            state_d = IDLE;
                end else if (hold_cnt_q == '0) begin
                    state_d = OPEN;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            OPEN: begin
                if (pick_found)     grant = 1'b1;
                else if (!owner_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (grant) begin
            state_d    = HOLD;
            owner_d    = pick_idx;
            hold_cnt_d = CNT_LOAD;
            rr_ptr_d   = (pick_idx == 3'(N_REQ - 1)) ? 3'd0 : pick_idx + 3'd1;
        end
    end

    // Outputs are computed from the next owner so gnt and digits align.
    always_comb begin
        busy_d     = (state_d != IDLE);
        switched_d = grant;
        gnt_d      = '0;
        sel_word   = BLANK_WORD;
        sel_blink  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_d == 3'(i)) begin
                gnt_d[i] = busy_d;
                sel_word = bus.req_digits[i*WORD_W +: WORD_W];
`ifdef SEVENSEG_ARB_BLINK_EN
                sel_blink = bus.blink[i];
`endif
            end
        end
        disp_d = busy_d ? sel_word : BLANK_WORD;
`ifdef SEVENSEG_ARB_BLINK_EN
        blink_cnt_d = blink_cnt_q + 1'b1;
        if (busy_d && sel_blink && blink_cnt_q[BLINK_LOG2])
            disp_d = BLANK_WORD;
`else
        sel_blink = sel_blink & 1'b0;
`endif
    end

    assign bus.gnt         = gnt_q;
    assign bus.owner_id    = owner_q;
    assign bus.busy        = busy_q;
    assign bus.switched    = switched_q & ~sel_blink | switched_q;
    assign bus.disp_digits = disp_q;

endmodule
